rwe_bus_ctrl: RTL and testbench

- Bus-side front end for a bank of rwe_reg bit cells; sits directly upstream of them.
- Converts APB-style slave transfers into per-register read and write strobes.
- Arbitrates hardware update requests, which reach the cells through the in_b/sel_ab path.
- Collects the AND-gated ro outputs of the cells into the read-data bus.

---
 rtl/rwe_bus_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_rwe_bus_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rwe_bus_ctrl.sv
// rwe_bus_ctrl
//   Bus-side front end for a bank of rwe_reg bit cells. Turns APB-style slave
//   transfers into per-register read/write strobes, arbitrates hardware update
//   requests (routed to the cells through in_b / sel_ab) and folds the cells'
//   AND-gated ro outputs into the read-data bus. Every output is registered.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   psel, penable       APB select / access phase
//   pwrite, paddr       direction (1 = write) and word address
//   pwdata              write data
//   prdata              read data (registered)
//   pready, pslverr     transfer complete / address error (valid with pready)
//   reg_wdata           bus data to in_a of every cell
//   reg_write           per-register write strobe
//   reg_sel_ab          per-register source select, 1 = hardware (in_b)
//   reg_read            per-register read enable
//   reg_ro              concatenated cell ro outputs, register i at [i*DW +: DW]
//   hw_req, hw_ack      hardware update request (level) / grant (1-cycle pulse)
module rwe_bus_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [AW-1:0]      paddr,
  input  logic [DW-1:0]      pwdata,
  output logic [DW-1:0]      prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [DW-1:0]      reg_wdata,
  output logic [NREG-1:0]    reg_write,
  output logic [NREG-1:0]    reg_sel_ab,
  output logic [NREG-1:0]    reg_read,
  input  logic [NREG*DW-1:0] reg_ro,
  input  logic [NREG-1:0]    hw_req,
  output logic [NREG-1:0]    hw_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  state_t            state, state_nx;

  // Transfer fields captured at the setup phase
  logic [AW-1:0]     addr_p0, addr_nx;
  logic              write_p0, write_nx;

  logic [DW-1:0]     prdata_nx;
  logic              pready_nx;
  logic              pslverr_nx;
  logic [DW-1:0]     reg_wdata_nx;
  logic [NREG-1:0]   reg_write_nx;
  logic [NREG-1:0]   reg_sel_ab_nx;
  logic [NREG-1:0]   reg_read_nx;
  logic [NREG-1:0]   hw_ack_nx;

  logic [NREG-1:0]   addr_dec;
  logic              addr_err;
  logic [DW-1:0]     ro_or;
  logic [NREG-1:0]   bus_wr;
  logic [NREG-1:0]   bus_rd;
  logic [NREG-1:0]   hw_mask;
  logic [NREG-1:0]   grant;

  always_comb begin
    addr_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_p0 == AW'(i)) addr_dec[i] = 1'b1;
    end
  end

  // Addresses NREG..2**AW-1 decode to nothing and are flagged as errors
  assign addr_err = ({1'b0, addr_p0} >= NREG_W);

  // Cells gate ro with their read enable, so a plain OR selects the addressed one
  always_comb begin
    ro_or = '0;
    for (int i = 0; i < NREG; i++) begin
      ro_or = ro_or | reg_ro[i*DW +: DW];
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_p0;
    write_nx     = write_p0;
    reg_wdata_nx = reg_wdata;
    prdata_nx    = prdata;
    pready_nx    = 1'b0;
    pslverr_nx   = 1'b0;
    bus_wr       = '0;
    bus_rd       = '0;
    hw_mask      = '0;

    case (state)
      IDLE: begin
        if (psel && !penable) begin
          addr_nx      = paddr;
          write_nx     = pwrite;
          reg_wdata_nx = pwdata;
          state_nx     = DECODE;
        end
      end
      DECODE: begin
        if (!psel) begin
          state_nx = IDLE;
        end else if (addr_err) begin
          state_nx   = RESP;
          pready_nx  = 1'b1;
          pslverr_nx = 1'b1;
          prdata_nx  = '0;
        end else begin
          state_nx = STROBE;
          if (write_p0) begin
            bus_wr  = addr_dec;
            // A hardware grant to the same cell waits one cycle so its data lands last
            hw_mask = addr_dec;
          end else begin
            bus_rd = addr_dec;
          end
        end
      end
      STROBE: begin
        state_nx  = RESP;
        pready_nx = 1'b1;
        prdata_nx = write_p0 ? '0 : ro_or;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // hw_ack masks the still-high request in the cycle after a grant
    grant         = hw_req & ~hw_ack & ~hw_mask;
    reg_write_nx  = bus_wr | grant;
    reg_sel_ab_nx = grant;
    reg_read_nx   = bus_rd;
    hw_ack_nx     = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered outputs and captured transfer fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0    <= '0;
      write_p0   <= 1'b0;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      reg_wdata  <= '0;
      reg_write  <= '0;
      reg_sel_ab <= '0;
      reg_read   <= '0;
      hw_ack     <= '0;
    end else begin
      addr_p0    <= addr_nx;
      write_p0   <= write_nx;
      prdata     <= prdata_nx;
      pready     <= pready_nx;
      pslverr    <= pslverr_nx;
      reg_wdata  <= reg_wdata_nx;
      reg_write  <= reg_write_nx;
      reg_sel_ab <= reg_sel_ab_nx;
      reg_read   <= reg_read_nx;
      hw_ack     <= hw_ack_nx;
    end
  end

endmodule

// File: tb/tb_rwe_bus_ctrl.sv
// tb_rwe_bus_ctrl
//   Directed bench for rwe_bus_ctrl. Two instances share the bus and request
//   inputs: an 8-register bank (power-of-two) and a 6-register bank where
//   addresses 6 and 7 must be rejected with pslverr.
module tb_rwe_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [7:0]  pwdata;
  logic [63:0] reg_ro;
  logic [7:0]  hw_req;

  logic [7:0]  prdata8, wdata8, write8, sel8, read8, ack8;
  logic        pready8, pslverr8;
  logic [7:0]  prdata6, wdata6;
  logic [5:0]  write6, sel6, read6, ack6;
  logic        pready6, pslverr6;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rwe_bus_ctrl #(.NREG(8), .DW(8), .AW(3)) dut8 (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata8), .pready(pready8),
    .pslverr(pslverr8), .reg_wdata(wdata8), .reg_write(write8),
    .reg_sel_ab(sel8), .reg_read(read8), .reg_ro(reg_ro),
    .hw_req(hw_req), .hw_ack(ack8)
  );

  rwe_bus_ctrl #(.NREG(6), .DW(8), .AW(3)) dut6 (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata6), .pready(pready6),
    .pslverr(pslverr6), .reg_wdata(wdata6), .reg_write(write6),
    .reg_sel_ab(sel6), .reg_read(read6), .reg_ro(reg_ro[47:0]),
    .hw_req(hw_req[5:0]), .hw_ack(ack6)
  );

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] ro;    // value presented on the addressed ro slice (reads)
    logic [7:0] st8;   // expected strobe vector, 8-register bank
    logic [7:0] prd;   // expected prdata for reads
    logic [5:0] st6;   // expected strobe vector, 6-register bank
    logic       err6;  // 6-register bank rejects the address
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting in the current cycle (S), checked through S+4
  task automatic do_xfer(input vec_t v, input string tag);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = v.wr;
    paddr   = v.addr;
    pwdata  = v.wdata;
    reg_ro  = v.wr ? 64'h0 : (64'(v.ro) << (int'(v.addr) * 8));
    step();  // S+1
    chk({tag, "_s1_strb8"}, 64'({write8, read8}), 64'h0);
    chk({tag, "_s1_strb6"}, 64'({write6, read6}), 64'h0);
    chk({tag, "_s1_rdy"}, 64'({pready8, pready6}), 64'h0);
    penable = 1'b1;
    step();  // S+2
    chk({tag, "_s2_wr8"}, 64'(write8), v.wr ? 64'(v.st8) : 64'h0);
    chk({tag, "_s2_rd8"}, 64'(read8), v.wr ? 64'h0 : 64'(v.st8));
    chk({tag, "_s2_sel8"}, 64'(sel8), 64'h0);
    chk({tag, "_s2_wdata8"}, 64'(wdata8), 64'(v.wdata));
    chk({tag, "_s2_rdy8"}, 64'(pready8), 64'h0);
    chk({tag, "_s2_wr6"}, 64'(write6), v.wr ? 64'(v.st6) : 64'h0);
    chk({tag, "_s2_rd6"}, 64'(read6), v.wr ? 64'h0 : 64'(v.st6));
    chk({tag, "_s2_rdyerr6"}, 64'({pready6, pslverr6}), v.err6 ? 64'h3 : 64'h0);
    if (v.err6) chk({tag, "_s2_prdata6"}, 64'(prdata6), 64'h0);
    step();  // S+3
    chk({tag, "_s3_strb8"}, 64'({write8, read8}), 64'h0);
    chk({tag, "_s3_rdyerr8"}, 64'({pready8, pslverr8}), 64'h2);
    if (!v.wr) chk({tag, "_s3_prdata8"}, 64'(prdata8), 64'(v.prd));
    chk({tag, "_s3_rdyerr6"}, 64'({pready6, pslverr6}), v.err6 ? 64'h0 : 64'h2);
    if (!v.wr && !v.err6) chk({tag, "_s3_prdata6"}, 64'(prdata6), 64'(v.prd));
    psel    = 1'b0;
    penable = 1'b0;
    reg_ro  = 64'h0;
    step();  // S+4
    chk({tag, "_s4_rdy"}, 64'({pready8, pready6}), 64'h0);
  endtask

  initial begin
    //         wr    addr  wdata  ro     st8    prd    st6    err6
    vecs[0] = '{1'b1, 3'd2, 8'hA5, 8'h00, 8'h04, 8'h00, 6'h04, 1'b0};
    vecs[1] = '{1'b0, 3'd5, 8'h00, 8'h3C, 8'h20, 8'h3C, 6'h20, 1'b0};
    vecs[2] = '{1'b0, 3'd7, 8'h12, 8'h99, 8'h80, 8'h99, 6'h00, 1'b1};
    vecs[3] = '{1'b1, 3'd6, 8'h5A, 8'h00, 8'h40, 8'h00, 6'h00, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 8'h34, 8'hC3, 8'h01, 8'hC3, 6'h01, 1'b0};
    vecs[5] = '{1'b1, 3'd7, 8'hFF, 8'h00, 8'h80, 8'h00, 6'h00, 1'b1};
    vecs[6] = '{1'b0, 3'd4, 8'h00, 8'h5E, 8'h10, 8'h5E, 6'h10, 1'b0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 3'd0; pwdata = 8'h00; reg_ro = 64'h0; hw_req = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out8", 64'({prdata8, pready8, pslverr8, wdata8, write8, sel8, read8, ack8}), 64'h0);
    chk("reset_out6", 64'({prdata6, pready6, pslverr6, wdata6, write6, sel6, read6, ack6}), 64'h0);
    rst = 1'b0;
    step();
    chk("idle_out8", 64'({pready8, write8, read8, ack8}), 64'h0);

    for (int i = 0; i < 7; i++) do_xfer(vecs[i], $sformatf("v%0d", i));

    // Parallel hardware grants while idle
    hw_req = 8'h81;
    step();
    chk("hw_wr8", 64'(write8), 64'h81);
    chk("hw_sel8", 64'(sel8), 64'h81);
    chk("hw_ack8", 64'(ack8), 64'h81);
    chk("hw_ack6", 64'(ack6), 64'h01);
    step();
    chk("hw_masked_wr8", 64'(write8), 64'h0);
    chk("hw_masked_ack8", 64'(ack8), 64'h0);
    hw_req = 8'h00;
    step();
    chk("hw_drop_ack8", 64'({write8, ack8}), 64'h0);

    // Bus write and hardware request to the same cell: hardware deferred one cycle
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd3; pwdata = 8'h11;
    step();  // S+1
    hw_req = 8'h08;
    penable = 1'b1;
    step();  // S+2
    chk("col_s2_wr8", 64'(write8), 64'h08);
    chk("col_s2_sel8", 64'(sel8), 64'h00);
    chk("col_s2_ack8", 64'(ack8), 64'h00);
    chk("col_s2_wdata8", 64'(wdata8), 64'h11);
    step();  // S+3
    chk("col_s3_wr8", 64'(write8), 64'h08);
    chk("col_s3_sel8", 64'(sel8), 64'h08);
    chk("col_s3_ack8", 64'(ack8), 64'h08);
    chk("col_s3_rdy8", 64'({pready8, pslverr8}), 64'h2);
    chk("col_s3_ack6", 64'(ack6), 64'h08);
    psel = 1'b0; penable = 1'b0;
    step();  // S+4
    hw_req = 8'h00;
    chk("col_s4_out8", 64'({write8, ack8, pready8}), 64'h0);
    step();
    chk("col_s5_ack8", 64'(ack8), 64'h0);

    // Abort: psel dropped in DECODE
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd4;
    step();
    psel = 1'b0;
    step();
    chk("abort_s2_strb8", 64'({write8, read8}), 64'h0);
    chk("abort_s2_rdy8", 64'(pready8), 64'h0);
    step();
    chk("abort_s3_rdy8", 64'({pready8, pready6}), 64'h0);

    // Reset during the STROBE cycle of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'h77;
    step();
    penable = 1'b1;
    step();  // STROBE
    chk("rst_pre_wr8", 64'(write8), 64'h02);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out8", 64'({prdata8, pready8, pslverr8, wdata8, write8, sel8, read8, ack8}), 64'h0);
    chk("rst_async_out6", 64'({prdata6, pready6, pslverr6, wdata6, write6, sel6, read6, ack6}), 64'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_post_out8", 64'({pready8, write8, read8}), 64'h0);
    do_xfer(vecs[1], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
